// File: rtl/fifo_flow_monitor_pkg.sv
// ============================================================================
// fifo_flow_monitor_pkg : shared FIFO indices, depths, threshold field layout
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_flow_monitor_pkg;

    // Bit position of each FIFO on every 5-bit status/strobe vector
    localparam int NUM_FIFOS = 5;
    localparam int IDX_MF    = 4;
    localparam int IDX_VC0   = 3;
    localparam int IDX_VC1   = 2;
    localparam int IDX_D0    = 1;
    localparam int IDX_D1    = 0;

    localparam int DEPTH_MF_DEF = 4;
    localparam int DEPTH_VC_DEF = 16;
    localparam int DEPTH_D_DEF  = 4;

    // Threshold field widths and offsets inside umbrales_I
    localparam int UMB_W   = 14;
    localparam int TW_MF   = 2;
    localparam int TW_VC   = 4;
    localparam int TW_D    = 2;
    localparam int OFS_MF  = 12;
    localparam int OFS_VC0 = 8;
    localparam int OFS_VC1 = 4;
    localparam int OFS_D0  = 2;
    localparam int OFS_D1  = 0;

    localparam int T_RST_MF = 1;
    localparam int T_RST_VC = 4;
    localparam int T_RST_D  = 1;

    // Counter must hold 0..DEPTH inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_flow_monitor_occupancy_counter.sv
// ============================================================================
// occupancy_counter : occupancy count, threshold register and status decode
// Revision: 1.0
// ============================================================================
`default_nettype none

module occupancy_counter
    import fifo_flow_monitor_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TW    = 2,
    parameter int T_RST = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    input  logic [TW-1:0] t_in,
    input  logic          push,
    input  logic          pop,
    output logic          empty,
    output logic          almost_empty,
    output logic          almost_full,
    output logic          error
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [TW-1:0] C_T_RST = TW'(T_RST);

    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] thr_q, thr_d;
    logic          error_q, error_d;
    logic          err_set;
    logic [CW-1:0] thr_ext;

    always_comb begin
        count_d = count_q;
        err_set = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == C_DEPTH) err_set = 1'b1;
                else                    count_d = count_q + C_ONE;
            end
            2'b01: begin
                if (count_q == '0) err_set = 1'b1;
                else               count_d = count_q - C_ONE;
            end
            2'b11: begin
                // Pop on empty has no data; the push still lands
                if (count_q == '0) begin
                    count_d = C_ONE;
                    err_set = 1'b1;
                end
            end
            default: ;
        endcase
        thr_d   = init ? t_in : thr_q;
        error_d = (error_q & ~init) | err_set;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            thr_q   <= C_T_RST;
            error_q <= 1'b0;
        end else begin
            count_q <= count_d;
            thr_q   <= thr_d;
            error_q <= error_d;
        end
    end

    assign thr_ext      = {{(CW-TW){1'b0}}, thr_q};
    assign empty        = (count_q == '0);
    assign almost_empty = (count_q <= thr_ext);
    assign almost_full  = (count_q >= (C_DEPTH - thr_ext));
    assign error        = error_q;

endmodule

`default_nettype wire

// File: rtl/fifo_flow_monitor.sv
// ============================================================================
// fifo_flow_monitor : occupancy/threshold status for the five link FIFOs
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_flow_monitor
    import fifo_flow_monitor_pkg::*;
#(
    parameter int DEPTH_MF = DEPTH_MF_DEF,
    parameter int DEPTH_VC = DEPTH_VC_DEF,
    parameter int DEPTH_D  = DEPTH_D_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [UMB_W-1:0] umbrales_I,
    input  logic [4:0]       push,
    input  logic [4:0]       pop,
    output logic [4:0]       FIFO_empty,
    output logic [4:0]       almost_empty,
    output logic [4:0]       almost_full,
    output logic [4:0]       FIFO_error,
    output logic             pause_out
);

    occupancy_counter #(.DEPTH(DEPTH_MF), .TW(TW_MF), .T_RST(T_RST_MF)) u_mf (
        .clk(clk), .reset(reset), .init(init),
        .t_in(umbrales_I[OFS_MF +: TW_MF]),
        .push(push[IDX_MF]), .pop(pop[IDX_MF]),
        .empty(FIFO_empty[IDX_MF]), .almost_empty(almost_empty[IDX_MF]),
        .almost_full(almost_full[IDX_MF]), .error(FIFO_error[IDX_MF])
    );

    occupancy_counter #(.DEPTH(DEPTH_VC), .TW(TW_VC), .T_RST(T_RST_VC)) u_vc0 (
        .clk(clk), .reset(reset), .init(init),
        .t_in(umbrales_I[OFS_VC0 +: TW_VC]),
        .push(push[IDX_VC0]), .pop(pop[IDX_VC0]),
        .empty(FIFO_empty[IDX_VC0]), .almost_empty(almost_empty[IDX_VC0]),
        .almost_full(almost_full[IDX_VC0]), .error(FIFO_error[IDX_VC0])
    );

    occupancy_counter #(.DEPTH(DEPTH_VC), .TW(TW_VC), .T_RST(T_RST_VC)) u_vc1 (
        .clk(clk), .reset(reset), .init(init),
        .t_in(umbrales_I[OFS_VC1 +: TW_VC]),
        .push(push[IDX_VC1]), .pop(pop[IDX_VC1]),
        .empty(FIFO_empty[IDX_VC1]), .almost_empty(almost_empty[IDX_VC1]),
        .almost_full(almost_full[IDX_VC1]), .error(FIFO_error[IDX_VC1])
    );

    occupancy_counter #(.DEPTH(DEPTH_D), .TW(TW_D), .T_RST(T_RST_D)) u_d0 (
        .clk(clk), .reset(reset), .init(init),
        .t_in(umbrales_I[OFS_D0 +: TW_D]),
        .push(push[IDX_D0]), .pop(pop[IDX_D0]),
        .empty(FIFO_empty[IDX_D0]), .almost_empty(almost_empty[IDX_D0]),
        .almost_full(almost_full[IDX_D0]), .error(FIFO_error[IDX_D0])
    );

    occupancy_counter #(.DEPTH(DEPTH_D), .TW(TW_D), .T_RST(T_RST_D)) u_d1 (
        .clk(clk), .reset(reset), .init(init),
        .t_in(umbrales_I[OFS_D1 +: TW_D]),
        .push(push[IDX_D1]), .pop(pop[IDX_D1]),
        .empty(FIFO_empty[IDX_D1]), .almost_empty(almost_empty[IDX_D1]),
        .almost_full(almost_full[IDX_D1]), .error(FIFO_error[IDX_D1])
    );

    assign pause_out = |almost_full;

endmodule

`default_nettype wire

// File: doc/fifo_flow_monitor.md
# fifo_flow_monitor

Tracks the occupancy of the five link FIFOs (MF, VC0, VC1, D0, D1) from their push/pop strobes. Compares each occupancy against the per-FIFO threshold field that the control FSM publishes on `umbrales_I`. Returns per-FIFO empty, almost-empty, almost-full and sticky error status to the control FSM, and a pause request to the upstream source. It is the status-producing end of the FSM↔flow-control interface: it consumes the thresholds the FSM emits and produces the `FIFO_empty`/`FIFO_error` vectors the FSM consumes.

## Interface
- `DEPTH_MF`, 4: MF FIFO depth (threshold field 2 bits)
- `DEPTH_VC`, 16: VC0/VC1 FIFO depth (threshold field 4 bits)
- `DEPTH_D`, 4: D0/D1 FIFO depth (threshold field 2 bits)
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `init`  in  1  load thresholds and clear sticky errors
- `umbrales_I`  in  14  threshold fields: MF[13:12], VC0[11:8], VC1[7:4], D0[3:2], D1[1:0]
- `push`  in  5  write strobe per FIFO, bit order MF=4, VC0=3, VC1=2, D0=1, D1=0 (same order on every 5-bit vector)
- `pop`  in  5  read strobe per FIFO
- `FIFO_empty`  out  5  occupancy == 0
- `almost_empty`  out  5  occupancy <= T
- `almost_full`  out  5  occupancy >= DEPTH − T
- `FIFO_error`  out  5  sticky overflow/underflow flag
- `pause_out`  out  1  OR of `almost_full`

## Operation
- Per FIFO: occupancy register, width = clog2(DEPTH)+1 (3 bits MF/D, 5 bits VC). Threshold register T, width of its field.
- Almost thresholds from a single field T: almost-empty at count <= T, almost-full at count >= DEPTH − T. Compute DEPTH − T at counter width; T=0 gives AF only when full.
- Per-cycle update, evaluated independently per FIFO, from current count c:
  - no strobe: hold.
  - push only: c < DEPTH → c+1; c == DEPTH → hold, set error (overflow).
  - pop only: c > 0 → c−1; c == 0 → hold, set error (underflow).
  - push & pop: 0 < c <= DEPTH → hold, no error (full+push+pop is legal). c == 0 → c becomes 1, set error (pop had no data).
- `FIFO_error` bits are sticky. Cleared only by reset or `init`. If `init` and a new error occur in the same cycle, the error wins (bit ends set).
- `init` high: T registers load from `umbrales_I`. Occupancy counts are not affected, and push/pop are still processed in that cycle. New thresholds take effect on flags from the next cycle.
- Reset (`reset`==0) overrides everything: counts 0, T = defaults (MF 1, VC0 4, VC1 4, D0 1, D1 1), errors 0.
- Status outputs are pure decodes of the count, T and error registers. No combinational path from `push`/`pop`/`init` to any output.

## Timing
- Output values during/after reset: `FIFO_empty`=5'b11111, `almost_empty`=5'b11111, `almost_full`=0, `FIFO_error`=0, `pause_out`=0.
- Latency: a strobe sampled at edge N is reflected in all flags after edge N (visible in cycle N+1). Same for error set and `init` load.
- Reset asserted mid-operation: all state returns to the reset values at the next edge, regardless of strobes.
- Strobes are not handshaked. The monitor never blocks; `pause_out` is advisory to the source.

## Structure
- Shared package: FIFO index constants (MF=4 … D1=0), depth constants, default threshold values, `umbrales_I` field offsets/widths.
- One sub-module, `occupancy_counter` (parameters DEPTH, TW). Holds count and T, and produces empty/ae/af/error. It is instantiated five times.
- The top level is only field slicing, instantiation and the `pause_out` OR.

## Test plan
- Reset, then idle 3 cycles → `FIFO_empty`=11111, `almost_empty`=11111, `almost_full`=0, `FIFO_error`=0.
- `init` with `umbrales_I`={2'd1,4'd4,4'd4,2'd1,2'd1}; 12 pushes to VC0 → `almost_full`[3]=1 and `pause_out`=1 the cycle after the 12th push, `almost_empty`[3]=0 after the 5th.
- Fill MF to 4, then push again → count stays 4, `FIFO_error`[4]=1 next cycle. Push+pop while full → count 4, no further change.
- Pop D1 while empty → `FIFO_error`[0]=1, `FIFO_empty`[0] stays 1. Push+pop D1 while empty → count 1, `FIFO_empty`[0]=0.
- With errors set, pulse `init` (no strobes) → `FIFO_error`=0 next cycle, counts unchanged. `init` plus an overflow push in the same cycle → that error bit remains 1.
- Mid-traffic with VC1 at 9, assert `reset` for 1 cycle with push asserted → count 0, T back to 4, all outputs at reset values.
